// File: rtl/key_event_scheduler_pkg.sv
// Shared constants, id-width helper and event record for the key event scheduler.
package key_event_pkg;

   localparam int unsigned KEY_N_MAX       = 16;
   localparam int unsigned KEY_SYNC_STAGES = 2;

   function automatic int unsigned key_idw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned KEY_IDW_MAX = key_idw(KEY_N_MAX);

   typedef struct packed {
      logic [KEY_IDW_MAX-1:0] id;
      logic                   is_long;
   } key_evt_t;

endpackage

// File: rtl/key_event_scheduler_channel.sv
// One key channel: synchronizer, debouncer, press pulse, and (KEY_LONG_PRESS_EN) hold timer.
module key_channel
   import key_event_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned LONG_CYCLES     = 50000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic press,
   output logic long_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [KEY_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                       sync;
   logic                       stable_q, stable_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       press_q, press_d;

   assign sync = sync_q[KEY_SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[KEY_SYNC_STAGES-2:0], key_in};
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

`ifdef KEY_LONG_PRESS_EN
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Saturating hold timer fires once per press and rearms only when stable drops.
   always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (stable_q) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         long_d = (hold_q == HOLD_MAX - 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   localparam int unsigned unused_long_cycles = LONG_CYCLES;
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_event_scheduler.sv
// N debounced keys merged onto one valid/ready press-event port by round-robin.
// Long-press events are produced only when KEY_LONG_PRESS_EN is defined.
module key_event_scheduler
   import key_event_pkg::*;
#(
   parameter int unsigned N               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned LONG_CYCLES     = 50000,
   localparam int unsigned IDW            = key_idw(N)
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   key_in,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_id,
   output logic           evt_long,
   output logic           evt_overrun
);

   logic [N-1:0] press, long_press;

   for (genvar c = 0; c < N; c++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .key_in     (key_in[c]),
         .press      (press[c]),
         .long_press (long_press[c])
      );
   end

   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   pending_long_q, pending_long_d;
   logic [IDW-1:0] last_grant_q, last_grant_d;
   logic           evt_valid_q, evt_valid_d;
   key_evt_t       evt_q, evt_d;
   logic           overrun_q, overrun_d;

   logic [N-1:0]   req, gnt_oh, clr_short, clr_long;
   logic [IDW-1:0] gnt_idx;
   logic           found, gnt_short, load;
   int unsigned    probe;

   always_comb begin
      req     = pending_q | pending_long_q;
      found   = 1'b0;
      gnt_idx = '0;
      probe   = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         probe = (32'(last_grant_q) + i) % N;
         if (!found && req[probe]) begin
            found   = 1'b1;
            gnt_idx = IDW'(probe);
         end
      end
      // A channel's short event is always served before its long one.
      gnt_short = pending_q[gnt_idx];
      load      = (!evt_valid_q || evt_ready) && found;
      gnt_oh    = N'(1) << gnt_idx;
      clr_short = (load && gnt_short)  ? gnt_oh : '0;
      clr_long  = (load && !gnt_short) ? gnt_oh : '0;

      pending_d      = (pending_q & ~clr_short) | press;
      pending_long_d = (pending_long_q & ~clr_long) | long_press;
      overrun_d      = (|(press & pending_q & ~clr_short)) ||
                       (|(long_press & pending_long_q & ~clr_long));

      evt_d        = evt_q;
      evt_valid_d  = evt_valid_q;
      last_grant_d = last_grant_q;
      if (load) begin
         evt_valid_d   = 1'b1;
         evt_d.id      = KEY_IDW_MAX'(gnt_idx);
         evt_d.is_long = !gnt_short;
         last_grant_d  = gnt_idx;
      end else if (evt_ready) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q      <= '0;
         pending_long_q <= '0;
         last_grant_q   <= IDW'(N - 1);
         evt_valid_q    <= 1'b0;
         evt_q          <= '0;
         overrun_q      <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         pending_long_q <= pending_long_d;
         last_grant_q   <= last_grant_d;
         evt_valid_q    <= evt_valid_d;
         evt_q          <= evt_d;
         overrun_q      <= overrun_d;
      end
   end

   logic unused_id_bits;
   assign unused_id_bits = ^evt_q.id;

   assign evt_valid   = evt_valid_q;
   assign evt_id      = evt_q.id[IDW-1:0];
   assign evt_long    = evt_q.is_long;
   assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: latency table, hand-written corner sequences, random run vs. model.
module tb_key_event_scheduler;

   localparam int unsigned NK = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned LC = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key_in;
   logic          evt_valid;
   logic          evt_ready;
   logic [1:0]    evt_id;
   logic          evt_long;
   logic          evt_overrun;

   int unsigned total = 0;
   int unsigned bad   = 0;

   key_event_scheduler #(
      .N               (NK),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (LC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_id      (evt_id),
      .evt_long    (evt_long),
      .evt_overrun (evt_overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] mask;
      logic [2:0] n;
      logic [7:0] ids;
   } vec_t;

   vec_t tbl [5];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      key_in    = '0;
      evt_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Accepted events are logged as nibbles {long, 0, id}, oldest in the low nibble.
   task automatic collect(input int unsigned cyc, output int unsigned cnt,
                          output logic [31:0] seq, output int unsigned ov);
      cnt = 0;
      seq = '0;
      ov  = 0;
      for (int unsigned i = 0; i < cyc; i++) begin
         if (evt_overrun) ov++;
         if (evt_valid && evt_ready) begin
            if (cnt < 8) seq[4*cnt +: 4] = {evt_long, 1'b0, evt_id};
            cnt++;
         end
         tick();
      end
   endtask

   int unsigned rem     [NK];
   logic        lvl     [NK];
   logic        mst     [NK];
   int unsigned run     [NK];
   int unsigned presses [NK];
   int unsigned events  [NK];

   // Reference debouncer: a level is accepted after D consecutive samples differing from it.
   task automatic model_step(input int unsigned c);
      if (lvl[c] != mst[c]) begin
         run[c]++;
         if (run[c] == D) begin
            mst[c] = lvl[c];
            run[c] = 0;
            if (mst[c]) presses[c]++;
         end
      end else begin
         run[c] = 0;
      end
   endtask

   initial begin
      int unsigned cnt, ov, rov;
      logic [31:0] seq;
      logic        held;
      logic [1:0]  held_id;

      tbl[0] = '{mask: 4'b0100, n: 3'd1, ids: 8'h02};
      tbl[1] = '{mask: 4'b1011, n: 3'd3, ids: 8'h34};
      tbl[2] = '{mask: 4'b1111, n: 3'd4, ids: 8'hE4};
      tbl[3] = '{mask: 4'b1000, n: 3'd1, ids: 8'h03};
      tbl[4] = '{mask: 4'b0001, n: 3'd1, ids: 8'h00};

      rst_n     = 1'b0;
      key_in    = '0;
      evt_ready = 1'b1;
      #1;
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_id", 32'(evt_id), 0);
      chk("rst_long", 32'(evt_long), 0);
      chk("rst_ovr", 32'(evt_overrun), 0);

      for (int t = 0; t < 5; t++) begin
         do_reset();
         key_in = tbl[t].mask;
         repeat (D + 3) tick();
         chk("lat_pre", 32'(evt_valid), 0);
         for (int k = 0; k < int'(tbl[t].n); k++) begin
            tick();
            chk("lat_valid", 32'(evt_valid), 1);
            chk("lat_id", 32'(evt_id), 32'(tbl[t].ids[2*k +: 2]));
            chk("lat_long", 32'(evt_long), 0);
         end
         tick();
         chk("lat_tail", 32'(evt_valid), 0);
         key_in = '0;
         repeat (10) tick();
      end

      // Glitch one cycle short of the debounce window, then an exact-length hold.
      do_reset();
      key_in = 4'b0010;
      repeat (D - 1) tick();
      key_in = '0;
      collect(20, cnt, seq, ov);
      chk("glitch_none", cnt, 0);
      key_in = 4'b0010;
      repeat (D) tick();
      key_in = '0;
      collect(20, cnt, seq, ov);
      chk("hold_cnt", cnt, 1);
      chk("hold_id", seq[3:0], 4'h1);

      // Second burst after the pointer has reached channel 3 wraps back to 0.
      do_reset();
      key_in = 4'b1011;
      collect(20, cnt, seq, ov);
      chk("burst1_cnt", cnt, 3);
      chk("burst1_seq", seq[11:0], 12'h310);
      key_in = '0;
      repeat (10) tick();
      key_in = 4'b1011;
      collect(20, cnt, seq, ov);
      chk("burst2_cnt", cnt, 3);
      chk("burst2_seq", seq[11:0], 12'h310);
      key_in = '0;
      repeat (10) tick();

      // Back-pressure: one event held, one pending, a third press merges.
      do_reset();
      evt_ready = 1'b0;
      key_in = 4'b0100;
      collect(14, cnt, seq, ov);
      chk("bp_valid", 32'(evt_valid), 1);
      chk("bp_id", 32'(evt_id), 2);
      chk("bp_ov1", ov, 0);
      key_in = '0;
      collect(8, cnt, seq, ov);
      key_in = 4'b0100;
      collect(14, cnt, seq, ov);
      chk("bp_held_id", 32'(evt_id), 2);
      chk("bp_ov2", ov, 0);
      key_in = '0;
      collect(8, cnt, seq, ov);
      key_in = 4'b0100;
      collect(14, cnt, seq, ov);
      chk("bp_ov3", ov, 1);
      key_in = '0;
      evt_ready = 1'b1;
      collect(12, cnt, seq, ov);
      chk("bp_drain_cnt", cnt, 2);
      chk("bp_drain_seq", seq[7:0], 8'h22);

      // Asynchronous reset while an event is held and another is pending.
      do_reset();
      evt_ready = 1'b0;
      key_in = 4'b0011;
      repeat (D + 8) tick();
      chk("mid_valid", 32'(evt_valid), 1);
      rst_n  = 1'b0;
      key_in = '0;
      #1;
      chk("mid_rst_valid", 32'(evt_valid), 0);
      chk("mid_rst_id", 32'(evt_id), 0);
      chk("mid_rst_ovr", 32'(evt_overrun), 0);
      tick();
      tick();
      rst_n = 1'b1;
      evt_ready = 1'b1;
      collect(30, cnt, seq, ov);
      chk("mid_after_cnt", cnt, 0);

`ifdef KEY_LONG_PRESS_EN
      do_reset();
      key_in = 4'b0001;
      collect(40, cnt, seq, ov);
      chk("long_cnt", cnt, 2);
      chk("long_first_short", seq[3:0], 4'h0);
      chk("long_second_long", seq[7:4], 4'h8);
      key_in = '0;
      repeat (10) tick();
`endif

      // Randomized run against the reference debouncer; all presses must arrive.
      do_reset();
      for (int unsigned c = 0; c < NK; c++) begin
         rem[c] = 0; lvl[c] = 1'b0; mst[c] = 1'b0;
         run[c] = 0; presses[c] = 0; events[c] = 0;
      end
      held = 1'b0;
      held_id = '0;
      rov = 0;
      for (int unsigned cyc = 0; cyc < 1540; cyc++) begin
         for (int unsigned c = 0; c < NK; c++) begin
            if (cyc >= 1500) begin
               lvl[c] = 1'b0;
            end else if (rem[c] == 0) begin
               lvl[c] = !lvl[c];
               rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D - 1)
                                                     : $urandom_range(3 * D, 6 * D);
            end
            if (rem[c] != 0) rem[c]--;
            key_in[c] = lvl[c];
            model_step(c);
         end
         evt_ready = (cyc >= 1500) || ($urandom_range(0, 7) != 0);
         if (held) begin
            chk("rand_hold_valid", 32'(evt_valid), 1);
            chk("rand_hold_id", 32'(evt_id), 32'(held_id));
         end
         if (evt_overrun) rov++;
         if (evt_valid && evt_ready && !evt_long) events[evt_id]++;
`ifndef KEY_LONG_PRESS_EN
         if (evt_valid) chk("rand_long", 32'(evt_long), 0);
`endif
         held    = evt_valid && !evt_ready;
         held_id = evt_id;
         tick();
      end
      for (int unsigned c = 0; c < NK; c++) begin
         chk($sformatf("rand_events_ch%0d", c), events[c], presses[c]);
      end
      chk("rand_overrun", rov, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
